// File: rtl/fp_mem_add_seq_pkg.sv
// Shared types and constants for the memory-to-memory single-precision adder.
// Holds the FSM state encoding, the IEEE-754 special values and operand decode helpers.
package fp_mem_add_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CAP_B,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF  = 32'hFF80_0000;
    localparam logic [7:0]  EXP_BIAS = 8'd127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam logic [7:0]  SHIFT_SAT = 8'd26;

    // Magnitude ordering key: denormals collapse to zero so they never win the swap.
    function automatic logic [30:0] mag_key(input logic [31:0] value);
        return (value[30:23] == 8'd0) ? 31'd0 : value[30:0];
    endfunction

    // 26-bit significand with hidden one and two guard bits; zero for exponent 0.
    function automatic logic [25:0] sig_of(input logic [31:0] value);
        return (value[30:23] == 8'd0) ? 26'd0 : {1'b1, value[22:0], 2'b00};
    endfunction

endpackage

// File: rtl/fp_lzc24.sv
// Combinational leading-zero counter over a 24-bit vector.
// Returns 24 when the input is all zeros.
module fp_lzc24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);

    // Scanning upward lets the most significant set bit overwrite earlier hits.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (value[i]) count = 5'(23 - i);
        end
    end

endmodule

// File: rtl/fp_mem_add_seq.sv
// Sequential single-precision adder that reads two words from memory,
// adds them with truncation and writes the sum back to a destination word.
module fp_mem_add_seq
    import fp_mem_add_seq_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_dst,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result,
    output logic              err,
    output logic              mem_we,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t state, state_next;

    logic [ADDR_W-1:0] lat_a, lat_b, lat_dst;
    logic [31:0]       op_a, op_b;
    logic [25:0]       sig_x, sig_y;
    logic [7:0]        exp_x;
    logic              sign_x, sign_y, nan_flag;
    logic [26:0]       sum;
    logic [31:0]       sum_word;

    logic [31:0] x_c, y_c;
    logic [7:0]  diff;
    logic [25:0] sig_y_sh;
    logic        nan_c;
    logic [4:0]  lz24, lz;
    logic [9:0]  exp_n;
    logic [31:0] norm_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RD_A;
            S_RD_A:  state_next = S_RD_B;
            S_RD_B:  state_next = S_CAP_B;
            S_CAP_B: state_next = S_ALIGN;
            S_ALIGN: state_next = S_ADD;
            S_ADD:   state_next = S_NORM;
            S_NORM:  state_next = S_WR;
            S_WR:    state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        mem_we    = 1'b0;
        mem_mode  = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_RD_A: mem_addr = lat_a;
            S_RD_B: mem_addr = lat_b;
            S_WR: begin
                mem_we    = 1'b1;
                mem_mode  = 1'b0;
                mem_addr  = lat_dst;
                mem_wdata = sum_word;
            end
            default: ;
        endcase
    end

    // Larger magnitude becomes X; the smaller significand is aligned with guard bits kept.
    always_comb begin
        if (mag_key(op_b) > mag_key(op_a)) begin
            x_c = op_b;
            y_c = op_a;
        end else begin
            x_c = op_a;
            y_c = op_b;
        end
        diff     = x_c[30:23] - y_c[30:23];
        sig_y_sh = (diff >= SHIFT_SAT) ? 26'd0 : (sig_of(y_c) >> diff);
        nan_c    = (op_a[30:23] == EXP_MAX) || (op_b[30:23] == EXP_MAX);
    end

    fp_lzc24 u_lzc (
        .value (sum[25:2]),
        .count (lz24)
    );

    // A leading one can fall into the guard bits after near-cancellation.
    always_comb begin
        lz        = lz24;
        exp_n     = '0;
        norm_word = '0;
        if (lz24 == 5'd24) lz = sum[1] ? 5'd24 : 5'd25;
        if (nan_flag) begin
            norm_word = QNAN;
        end else if (sum == 27'd0) begin
            norm_word = '0;
        end else if (sum[26]) begin
            exp_n = {2'b00, exp_x} + 10'd1;
            if (exp_n >= {2'b00, EXP_MAX}) norm_word = sign_x ? NEG_INF : POS_INF;
            else                           norm_word = {sign_x, exp_n[7:0], sum[25:3]};
        end else begin
            exp_n = {2'b00, exp_x} - {5'b00000, lz};
            if (exp_n[9] || exp_n == 10'd0) norm_word = '0;
            else norm_word = {sign_x, exp_n[7:0], 23'((sum[24:0] << lz) >> 2)};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_a    <= '0;
            lat_b    <= '0;
            lat_dst  <= '0;
            op_a     <= '0;
            op_b     <= '0;
            sig_x    <= '0;
            sig_y    <= '0;
            exp_x    <= '0;
            sign_x   <= 1'b0;
            sign_y   <= 1'b0;
            nan_flag <= 1'b0;
            sum      <= '0;
            sum_word <= '0;
            result   <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    lat_a   <= addr_a;
                    lat_b   <= addr_b;
                    lat_dst <= addr_dst;
                end
                S_RD_B:  op_a <= mem_rdata;
                S_CAP_B: op_b <= mem_rdata;
                S_ALIGN: begin
                    sig_x    <= sig_of(x_c);
                    sig_y    <= sig_y_sh;
                    exp_x    <= x_c[30:23];
                    sign_x   <= x_c[31];
                    sign_y   <= y_c[31];
                    nan_flag <= nan_c;
                end
                S_ADD: sum <= (sign_x == sign_y) ? ({1'b0, sig_x} + {1'b0, sig_y})
                                                 : ({1'b0, sig_x} - {1'b0, sig_y});
                S_NORM: sum_word <= norm_word;
                S_WR: begin
                    result <= sum_word;
                    err    <= nan_flag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mem_add_seq.sv
// Directed testbench for fp_mem_add_seq with a synchronous-read memory model.
// Each scenario task drives its own stimulus and compares against hand-computed values.
module tb_fp_mem_add_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  addr_a, addr_b, addr_dst;
    logic        busy, done, err;
    logic [31:0] result;
    logic        mem_we, mem_mode;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [32];
    logic        load_en;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    int          we_count;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } vec_t;

    fp_mem_add_seq #(.ADDR_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .addr_dst  (addr_dst),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .err       (err),
        .mem_we    (mem_we),
        .mem_mode  (mem_mode),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: bench preload port has priority, read data appears the cycle after the read.
    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (mem_we && !mem_mode) mem[mem_addr] <= mem_wdata;
        if (mem_we) we_count <= we_count + 1;
        if (mem_mode) mem_rdata <= mem[mem_addr];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic load_word(input logic [4:0] addr, input logic [31:0] data);
        load_addr = addr;
        load_data = data;
        load_en   = 1'b1;
        @(posedge clk);
        #1;
        load_en   = 1'b0;
    endtask

    // Issues one start and returns the cycle (1 = cycle after the sampling edge) where done was seen.
    task automatic run_op(input logic [4:0] a, input logic [4:0] b, input logic [4:0] dst,
                          output int cycles, output bit timed_out);
        addr_a    = a;
        addr_b    = b;
        addr_dst  = dst;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        cycles    = 0;
        timed_out = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (done) begin
                cycles    = i;
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        load_word(5'd1, 32'h3F80_0000);
        load_word(5'd2, 32'h4000_0000);
        load_word(5'd4, 32'h3FC0_0000);
        load_word(5'd5, 32'hBFC0_0000);
        load_word(5'd8, 32'h7F7F_FFFF);
        load_word(5'd9, 32'h7FC0_0000);
        load_word(5'd11, 32'h3F80_0000);
        checks++; if (busy !== 1'b0)      begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)      begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0)       begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        checks++; if (mem_we !== 1'b0)    begin failures++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_mode !== 1'b1)  begin failures++; $display("[TB] FAIL reset_mem_mode: got %b expected 1", mem_mode); end
        checks++; if (result !== 32'd0)   begin failures++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
        checks++; if (mem_addr !== 5'd0)  begin failures++; $display("[TB] FAIL reset_mem_addr: got %h expected 00", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin failures++; $display("[TB] FAIL reset_mem_wdata: got %h expected 00000000", mem_wdata); end
        reset = 1'b1;
    endtask

    task automatic test_basic_add();
        int cycles;
        bit timed_out;
        run_op(5'd1, 5'd2, 5'd3, cycles, timed_out);
        checks++; if (timed_out || cycles != 8) begin failures++; $display("[TB] FAIL basic_done_cycle: got %0d (timeout %0d) expected 8", cycles, timed_out); end
        checks++; if (mem[3] !== 32'h4040_0000) begin failures++; $display("[TB] FAIL basic_mem: got %h expected 40400000", mem[3]); end
        checks++; if (result !== 32'h4040_0000) begin failures++; $display("[TB] FAIL basic_result: got %h expected 40400000", result); end
        checks++; if (err !== 1'b0)             begin failures++; $display("[TB] FAIL basic_err: got %b expected 0", err); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_idle: got done %b busy %b expected 0 0", done, busy); end
    endtask

    task automatic test_cancellation();
        int cycles;
        bit timed_out;
        run_op(5'd4, 5'd5, 5'd6, cycles, timed_out);
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL cancel_timeout: got timeout expected done"); end
        checks++; if (mem[6] !== 32'h0000_0000) begin failures++; $display("[TB] FAIL cancel_mem: got %h expected 00000000", mem[6]); end
    endtask

    task automatic test_overflow();
        int cycles;
        bit timed_out;
        run_op(5'd8, 5'd8, 5'd15, cycles, timed_out);
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL overflow_timeout: got timeout expected done"); end
        checks++; if (mem[15] !== 32'h7F80_0000) begin failures++; $display("[TB] FAIL overflow_mem: got %h expected 7f800000", mem[15]); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL overflow_err: got %b expected 0", err); end
    endtask

    task automatic test_nan();
        int cycles;
        bit timed_out;
        run_op(5'd9, 5'd11, 5'd16, cycles, timed_out);
        checks++; if (timed_out) begin failures++; $display("[TB] FAIL nan_timeout: got timeout expected done"); end
        checks++; if (mem[16] !== 32'h7FC0_0000) begin failures++; $display("[TB] FAIL nan_mem: got %h expected 7fc00000", mem[16]); end
        checks++; if (result !== 32'h7FC0_0000)  begin failures++; $display("[TB] FAIL nan_result: got %h expected 7fc00000", result); end
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL nan_err: got %b expected 1", err); end
    endtask

    task automatic test_vectors();
        vec_t vecs[8];
        int cycles;
        bit timed_out;
        vecs[0] = '{32'h3F80_0000, 32'hBF40_0000, 32'h3E80_0000};
        vecs[1] = '{32'hC040_0000, 32'h3F80_0000, 32'hC000_0000};
        vecs[2] = '{32'h00C0_0000, 32'h8080_0000, 32'h0000_0000};
        vecs[3] = '{32'h0000_0001, 32'hC000_0000, 32'hC000_0000};
        vecs[4] = '{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000};
        vecs[5] = '{32'hFF7F_FFFF, 32'hFF7F_FFFF, 32'hFF80_0000};
        vecs[6] = '{32'h4040_0000, 32'h4000_0000, 32'h40A0_0000};
        vecs[7] = '{32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000};
        for (int i = 0; i < 8; i++) begin
            load_word(5'd12, vecs[i].a);
            load_word(5'd13, vecs[i].b);
            run_op(5'd12, 5'd13, 5'd14, cycles, timed_out);
            checks++;
            if (timed_out || mem[14] !== vecs[i].sum || err !== 1'b0) begin
                failures++;
                $display("[TB] FAIL vector_%0d: %h + %h got %h err %b expected %h err 0",
                         i, vecs[i].a, vecs[i].b, mem[14], err, vecs[i].sum);
            end
        end
    endtask

    task automatic test_reset_abort();
        int cycles;
        bit timed_out;
        int we_before;
        load_word(5'd7, 32'h1234_5678);
        we_before = we_count;
        addr_a   = 5'd1;
        addr_b   = 5'd2;
        addr_dst = 5'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_busy_before: got %b expected 1", busy); end
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)   begin failures++; $display("[TB] FAIL abort_busy_now: got %b expected 0", busy); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("[TB] FAIL abort_mem_we: got %b expected 0", mem_we); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (we_count != we_before) begin failures++; $display("[TB] FAIL abort_writes: got %0d expected %0d", we_count, we_before); end
        checks++; if (mem[7] !== 32'h1234_5678) begin failures++; $display("[TB] FAIL abort_dst: got %h expected 12345678", mem[7]); end
        run_op(5'd1, 5'd2, 5'd7, cycles, timed_out);
        checks++; if (timed_out || cycles != 8) begin failures++; $display("[TB] FAIL abort_restart_cycle: got %0d expected 8", cycles); end
        checks++; if (mem[7] !== 32'h4040_0000) begin failures++; $display("[TB] FAIL abort_restart_mem: got %h expected 40400000", mem[7]); end
    endtask

    // A prior op is still in WR when start rises, so its first two samples must be ignored.
    task automatic test_back_to_back();
        logic [31:0] done_res[4];
        logic [31:0] mem1_at_second;
        int          done_n;
        load_word(5'd1, 32'h4040_0000);
        load_word(5'd10, 32'h0000_0000);
        addr_a   = 5'd1;
        addr_b   = 5'd2;
        addr_dst = 5'd10;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        addr_dst       = 5'd1;
        start          = 1'b1;
        done_n         = 0;
        mem1_at_second = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (done_n < 4) done_res[done_n] = result;
                if (done_n == 1) mem1_at_second = mem[1];
                done_n++;
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done_n != 3) begin failures++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", done_n); end
        checks++; if (mem[10] !== 32'h40A0_0000) begin failures++; $display("[TB] FAIL b2b_prior_mem: got %h expected 40a00000", mem[10]); end
        checks++; if (done_n >= 2 && mem1_at_second !== 32'h40A0_0000) begin failures++; $display("[TB] FAIL b2b_first_mem: got %h expected 40a00000", mem1_at_second); end
        checks++; if (done_n >= 3 && done_res[2] !== 32'h40E0_0000) begin failures++; $display("[TB] FAIL b2b_second_result: got %h expected 40e00000", done_res[2]); end
        checks++; if (mem[1] !== 32'h40E0_0000) begin failures++; $display("[TB] FAIL b2b_final_mem: got %h expected 40e00000", mem[1]); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle: got busy %b expected 0", busy); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        we_count  = 0;
        reset     = 1'b0;
        start     = 1'b0;
        addr_a    = '0;
        addr_b    = '0;
        addr_dst  = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_add();
        test_cancellation();
        test_overflow();
        test_nan();
        test_vectors();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
